dmux_dispatch_4ch: RTL
======================

# dmux_dispatch_4ch

Sequential controller that schedules the 1x4 4-bit demultiplexer datapath: accepts a 4-bit stream over a valid/ready handshake and dispatches each word to one of four output channels, each backed by a one-entry holding register. Destination is chosen either by an explicit 2-bit address or by a skip-busy round-robin pointer. A flush request drains all channels and reports completion, and a wrap-around counter tracks accepted words. It sits between a single producer and four independent consumers.

## Interface
- DATA_W, 4, width of data words and of each output channel

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = addressed (use in_dest), 1 = round-robin
- in_data  input  DATA_W  input word
- in_dest  input  2  destination channel in addressed mode (0=a,1=b,2=c,3=d); ignored in round-robin
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle (combinational)
- flush  input  1  request drain of all channels
- flush_done  output  1  one-cycle pulse when drain completes
- out_a, out_b, out_c, out_d  output  DATA_W  channel data; slot contents when valid, else 0
- out_valid  output  4  per-channel valid (bit 0 = a … bit 3 = d)
- out_ready  input  4  per-channel consumer ready
- rr_ptr  output  2  current round-robin pointer
- xfer_cnt  output  8  accepted-word count

## Operation
- Slot k can accept when it is empty, or full with out_ready[k]=1 this cycle (drain and refill in the same edge permitted).
- Target: addressed mode → in_dest; round-robin mode → first acceptable channel scanning rr_ptr, rr_ptr+1, … mod 4.
- in_ready = 0 when rst=1, flush=1, or state=DRAIN; otherwise 1 in addressed mode if target slot acceptable; 1 in round-robin if any slot acceptable.
- Acceptance (in_valid & in_ready at edge): slot[target] ← in_data, out_valid[target] ← 1; xfer_cnt ← xfer_cnt+1 (255→0 wraps); in round-robin mode rr_ptr ← target+1 mod 4. rr_ptr unchanged on addressed-mode acceptance.
- Drain: out_valid[k] & out_ready[k] at edge with no refill → out_valid[k] ← 0.
- out_x driven as slot AND out_valid (zero when invalid).
- FSM states RUN, DRAIN:
  - RUN → DRAIN when flush=1 (no word accepted that cycle).
  - DRAIN: no acceptance; consumers continue draining. When all out_valid=0 → flush_done=1 for that cycle, rr_ptr ← 0, next state RUN.
  - flush level ignored while in DRAIN; if still high on return to RUN, re-enters DRAIN next edge (done pulses again once empty).
- mode may change any cycle; takes effect on the same cycle's target computation; rr_ptr retained.

## Timing
- Reset (asynchronous, immediate): state=RUN, out_valid=0000, all out_x=0, slots=0, rr_ptr=0, xfer_cnt=0, flush_done=0, in_ready=0 while rst high.
- Latency: word accepted at edge N shows on out_x with out_valid set after edge N.
- in_ready combinationally depends on out_ready, mode, in_dest, flush, state; no combinational path from in_valid to in_ready.
- Full-rate throughput: one word per cycle into any channel whose consumer holds out_ready=1.
- flush_done is combinational on DRAIN & all-empty, asserted exactly one cycle per drain.
- Reset mid-transfer discards all slot contents and any pending flush.

## Test plan
- Reset then addressed mode, in_dest=2, in_data=4'hA, out_ready=0000 → after one edge out_valid=0100, out_c=4'hA, others 0, xfer_cnt=1; second word to dest 2 → in_ready=0.
- Round-robin, all out_ready=1, stream 1,2,3,4,5 → out_a=1,b=2,c=3,d=4,a=5 on consecutive cycles; rr_ptr 0→1→2→3→0→1.
- Round-robin skip-busy: slot b full with out_ready[1]=0, rr_ptr=1 → word goes to c, rr_ptr=3; all four full and out_ready=0000 → in_ready=0.
- Same-edge drain/refill: slot a full, out_ready[0]=1, new word for a → in_ready=1, out_a updates, out_valid[0] stays 1.
- Flush with slots a,d full, out_ready held 0 for 3 cycles then 1001 → in_ready=0 throughout, flush_done pulses once on the cycle after both drain, rr_ptr=0.
- 256 accepted words → xfer_cnt wraps to 0; assert rst mid-stream → all outputs zero immediately, asynchronously.

Source files
------------

// File: rtl/dmux_dispatch_4ch.sv
// 1x4 demux dispatcher: valid/ready input, four one-entry channel slots, addressed or skip-busy round-robin.
// Results show one cycle after acceptance; in_ready drops when the target (or every) slot is blocked, or during drain.
module dmux_dispatch_4ch #(
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic [1:0]        in_dest,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   output logic              flush_done,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [DATA_W-1:0] out_c,
   output logic [DATA_W-1:0] out_d,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [1:0]        rr_ptr,
   output logic [7:0]        xfer_cnt
);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] slot [4];
   logic [3:0]        acceptable;
   logic [1:0]        rr_target;
   logic [1:0]        target;
   logic [1:0]        idx;
   logic              rr_found;
   logic              accept;

   // A full slot can still take a word when its consumer empties it on the same edge.
   assign acceptable = ~out_valid | out_ready;

   always_comb begin
      rr_found  = 1'b0;
      rr_target = rr_ptr;
      idx       = '0;
      for (int i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!rr_found && acceptable[idx]) begin
            rr_found  = 1'b1;
            rr_target = idx;
         end
      end
   end

   assign target     = mode ? rr_target : in_dest;
   assign in_ready   = !rst && !flush && (state == RUN) && (mode ? rr_found : acceptable[in_dest]);
   assign accept     = in_valid && in_ready;
   assign flush_done = (state == DRAIN) && (out_valid == 4'b0000);

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = DRAIN;
         DRAIN:   if (out_valid == 4'b0000) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         out_valid <= 4'b0000;
         rr_ptr    <= 2'd0;
         xfer_cnt  <= 8'd0;
         for (int k = 0; k < 4; k++) slot[k] <= '0;
      end else begin
         state <= state_nxt;
         for (int k = 0; k < 4; k++) begin
            if (accept && target == 2'(k)) begin
               slot[k]      <= in_data;
               out_valid[k] <= 1'b1;
            end else if (out_valid[k] && out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
         if (accept) xfer_cnt <= xfer_cnt + 8'd1;
         if (flush_done)          rr_ptr <= 2'd0;
         else if (accept && mode) rr_ptr <= target + 2'd1;
      end
   end

   // Slot contents persist after drain; mask them so idle channels read zero.
   assign out_a = slot[0] & {DATA_W{out_valid[0]}};
   assign out_b = slot[1] & {DATA_W{out_valid[1]}};
   assign out_c = slot[2] & {DATA_W{out_valid[2]}};
   assign out_d = slot[3] & {DATA_W{out_valid[3]}};

endmodule
